// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stalls, memory waits, branch/jump flushes
// and halt handling for a five-stage pipeline. Pipeline-register enables,
// flushes and pc_en are combinational; halted and stall_count are registered.
module hazard_unit #(
    parameter int STALL_CNT_W = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   dmem_req,
    input  logic                   idex_dREN,
    input  logic [4:0]             idex_rt,
    input  logic [4:0]             ifid_rs,
    input  logic [4:0]             ifid_rt,
    input  logic                   branch_taken,
    input  logic                   jump,
    input  logic                   halt,
    output logic                   pc_en,
    output logic                   ifid_enable,
    output logic                   idex_enable,
    output logic                   exmem_enable,
    output logic                   memwb_enable,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   memwb_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_halted;
    logic [STALL_CNT_W-1:0] r_stall_count;
    logic                   w_load_use;
    logic                   w_mem_wait;

    // A load in EX whose destination feeds the instruction in ID; $zero never counts.
    assign w_load_use = idex_dREN && (idex_rt != 5'd0) &&
                        ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    assign w_mem_wait = dmem_req && !dhit;

    // State register; reset wins over everything, including HALTED.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= RUN;
        else     r_state <= w_state_next;
    end

    // Next state and pipeline controls, highest-priority condition first.
    always_comb begin
        w_state_next = r_state;
        pc_en        = 1'b0;
        ifid_enable  = 1'b0;
        idex_enable  = 1'b0;
        exmem_enable = 1'b0;
        memwb_enable = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        memwb_flush  = 1'b0;
        if (r_state != HALTED) begin
            if (halt) begin
                w_state_next = HALTED;
            end else if (w_mem_wait) begin
                // Freeze the whole pipeline and keep the current state.
                w_state_next = r_state;
            end else if (branch_taken) begin
                // Wrong-path instructions in IF/ID, ID/EX and EX/MEM are squashed.
                w_state_next = RUN;
                pc_en        = 1'b1;
                ifid_enable  = 1'b1;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                ifid_flush   = 1'b1;
                idex_flush   = 1'b1;
                exmem_flush  = 1'b1;
            end else if ((r_state == RUN) && w_load_use) begin
                // Hold PC and IF/ID, insert a bubble into ID/EX.
                w_state_next = LDSTALL;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                idex_flush   = 1'b1;
            end else begin
                // Normal flow; an I-miss bubbles IF/ID, a jump squashes the slot.
                w_state_next = RUN;
                pc_en        = ihit;
                ifid_enable  = 1'b1;
                idex_enable  = 1'b1;
                exmem_enable = 1'b1;
                memwb_enable = 1'b1;
                ifid_flush   = !ihit || jump;
            end
        end
    end

    // Halted flag rises on the edge that enters HALTED and sticks until reset.
    always_ff @(posedge CLK) begin
        if (RST)                         r_halted <= 1'b0;
        else if (w_state_next == HALTED) r_halted <= 1'b1;
    end

    // Saturating count of cycles where the PC did not advance while running.
    always_ff @(posedge CLK) begin
        if (RST)
            r_stall_count <= '0;
        else if ((r_state != HALTED) && !pc_en && (r_stall_count != '1))
            r_stall_count <= r_stall_count + STALL_CNT_W'(1);
    end

    assign halted      = r_halted;
    assign stall_count = r_stall_count;

endmodule
